// File: rtl/atm_pkg.sv
// Shared types for the ATM session controller: session state encoding and menu op codes.
package atm_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_PIN      = 4'd1,
    ST_MENU     = 4'd2,
    ST_AMOUNT   = 4'd3,
    ST_SHOW     = 4'd4,
    ST_DISPENSE = 4'd5,
    ST_EJECT    = 4'd6,
    ST_CAPTURE  = 4'd7
  } atm_state_e;

  typedef enum logic [1:0] {
    OP_BALANCE  = 2'b00,
    OP_WITHDRAW = 2'b01,
    OP_RESERVED = 2'b10,
    OP_EXIT     = 2'b11
  } atm_op_e;

  // States that wait on the user and so honour card removal, cancel and timeout.
  function automatic logic is_input_state(atm_state_e s);
    return (s == ST_PIN) || (s == ST_MENU) || (s == ST_AMOUNT);
  endfunction

endpackage

// File: rtl/atm_timeout_ctr.sv
// Inactivity counter: expired_o rises once LIMIT enabled cycles pass without a clear.
module atm_timeout_ctr #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = enable_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/atm_session_fsm.sv
// Registered ATM session controller: card, PIN with lockout, menu, withdrawal, eject/capture.
// Define ATM_TIMEOUT_EN to add the inactivity timeout in PIN/MENU/AMOUNT.
module atm_session_fsm
  import atm_pkg::*;
#(
  parameter int MAX_PIN_TRIES  = 3,
  parameter int AMT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             card_in,
  input  logic             cancel,
  input  logic             pin_vld,
  input  logic             pin_ok,
  input  logic [AMT_W-1:0] bal_in,
  input  logic             op_vld,
  input  logic [1:0]       op_sel,
  input  logic             amt_vld,
  input  logic [AMT_W-1:0] amt,
  output logic [3:0]       state_o,
  output logic [AMT_W-1:0] bal_o,
  output logic             bal_show,
  output logic             dispense,
  output logic [AMT_W-1:0] dispense_amt,
  output logic             insuff,
  output logic             eject,
  output logic             capture,
  output logic [3:0]       tries_left
);

  if (MAX_PIN_TRIES < 1 || MAX_PIN_TRIES > 15) begin : g_bad_tries
    $error("MAX_PIN_TRIES must be in 1..15");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  localparam logic [3:0] MAX_TRIES = 4'(MAX_PIN_TRIES);

  atm_state_e       state_q, state_d;
  logic [AMT_W-1:0] bal_q, bal_d;
  logic [AMT_W-1:0] disp_amt_q, disp_amt_d;
  logic [3:0]       tries_q, tries_d;
  logic             bal_show_q, bal_show_d;
  logic             dispense_q, dispense_d;
  logic             insuff_q, insuff_d;
  logic             eject_q, eject_d;
  logic             capture_q, capture_d;
  logic             timeout;
  logic             abort;

`ifdef ATM_TIMEOUT_EN
  logic to_clear;

  assign to_clear = cancel || pin_vld || op_vld || amt_vld || (state_d != state_q);

  atm_timeout_ctr #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (to_clear),
    .enable_i (is_input_state(state_q)),
    .expired_o(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // Any of these pre-empts the strobes of the input-waiting states.
  assign abort = !card_in || cancel || timeout;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: default every comb output first so no path leaves it unassigned (no latches).
    state_d = state_q;
    if (is_input_state(state_q) && !card_in) begin
      state_d = ST_IDLE;
    end else if (is_input_state(state_q) && (cancel || timeout)) begin
      state_d = ST_EJECT;
    end else begin
      case (state_q)
        ST_IDLE: if (card_in) state_d = ST_PIN;
        ST_PIN: begin
          if (pin_vld) begin
            if (pin_ok)              state_d = ST_MENU;
            else if (tries_q <= 4'd1) state_d = ST_CAPTURE;
          end
        end
        ST_MENU: begin
          if (op_vld) begin
            case (op_sel)
              OP_BALANCE:  state_d = ST_SHOW;
              OP_WITHDRAW: state_d = ST_AMOUNT;
              OP_EXIT:     state_d = ST_EJECT;
              default:     state_d = ST_MENU;
            endcase
          end
        end
        ST_AMOUNT: if (amt_vld) state_d = (amt != '0 && amt <= bal_q) ? ST_DISPENSE : ST_MENU;
        ST_SHOW, ST_DISPENSE: state_d = ST_MENU;
        ST_EJECT, ST_CAPTURE: if (!card_in) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bal_d      = bal_q;
    disp_amt_d = disp_amt_q;
    tries_d    = tries_q;
    insuff_d   = 1'b0;

    case (state_q)
      ST_PIN: begin
        if (!abort && pin_vld) begin
          if (pin_ok) begin
            bal_d   = bal_in;
            tries_d = MAX_TRIES;
          end else begin
            tries_d = tries_q - 4'd1;
          end
        end
      end
      ST_AMOUNT: begin
        if (!abort && amt_vld && amt != '0) begin
          if (amt <= bal_q) begin
            bal_d      = bal_q - amt;
            disp_amt_d = amt;
          end else begin
            insuff_d = 1'b1;
          end
        end
      end
      default: ;
    endcase

    // Every path back to IDLE ends the session.
    if (state_d == ST_IDLE && state_q != ST_IDLE) begin
      bal_d   = '0;
      tries_d = MAX_TRIES;
    end

    bal_show_d = (state_d == ST_SHOW);
    dispense_d = (state_d == ST_DISPENSE);
    eject_d    = (state_d == ST_EJECT) && (state_q != ST_EJECT);
    capture_d  = (state_d == ST_CAPTURE) && (state_q != ST_CAPTURE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bal_q      <= '0;
      disp_amt_q <= '0;
      tries_q    <= MAX_TRIES;
      bal_show_q <= 1'b0;
      dispense_q <= 1'b0;
      insuff_q   <= 1'b0;
      eject_q    <= 1'b0;
      capture_q  <= 1'b0;
    end else begin
      bal_q      <= bal_d;
      disp_amt_q <= disp_amt_d;
      tries_q    <= tries_d;
      bal_show_q <= bal_show_d;
      dispense_q <= dispense_d;
      insuff_q   <= insuff_d;
      eject_q    <= eject_d;
      capture_q  <= capture_d;
    end
  end

  assign state_o      = state_q;
  assign bal_o        = bal_q;
  assign dispense_amt = disp_amt_q;
  assign tries_left   = tries_q;
  assign bal_show     = bal_show_q;
  assign dispense     = dispense_q;
  assign insuff       = insuff_q;
  assign eject        = eject_q;
  assign capture      = capture_q;

endmodule

// File: tb/tb_atm_session_fsm.sv
// Self-checking bench for atm_session_fsm: vector table, hand-written corner sequences,
// and randomized traffic against a behavioural session model.
module tb_atm_session_fsm;
  import atm_pkg::*;

  localparam int MAX = 3;
  localparam int AW  = 16;
  localparam int TO  = 8;

  localparam logic [4:0] P_NONE = 5'b00000;
  localparam logic [4:0] P_SHOW = 5'b10000;
  localparam logic [4:0] P_DISP = 5'b01000;
  localparam logic [4:0] P_INS  = 5'b00100;
  localparam logic [4:0] P_EJ   = 5'b00010;
  localparam logic [4:0] P_CAP  = 5'b00001;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          card_in = 1'b0, cancel = 1'b0, pin_vld = 1'b0, pin_ok = 1'b0;
  logic          op_vld = 1'b0, amt_vld = 1'b0;
  logic [1:0]    op_sel = 2'b00;
  logic [AW-1:0] bal_in = '0, amt = '0;
  logic [3:0]    state_o, tries_left;
  logic [AW-1:0] bal_o, dispense_amt;
  logic          bal_show, dispense, insuff, eject, capture;

  always #5 clk = ~clk;

  atm_session_fsm #(
    .MAX_PIN_TRIES (MAX),
    .AMT_W         (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .card_in(card_in), .cancel(cancel),
    .pin_vld(pin_vld), .pin_ok(pin_ok), .bal_in(bal_in),
    .op_vld(op_vld), .op_sel(op_sel), .amt_vld(amt_vld), .amt(amt),
    .state_o(state_o), .bal_o(bal_o), .bal_show(bal_show), .dispense(dispense),
    .dispense_amt(dispense_amt), .insuff(insuff), .eject(eject),
    .capture(capture), .tries_left(tries_left)
  );

  typedef struct packed {
    logic card, cancel, pv, pok;
    logic [AW-1:0] bin;
    logic ov;
    logic [1:0] os;
    logic av;
    logic [AW-1:0] a;
  } in_t;

  typedef struct packed {
    logic [3:0]    st;
    logic [AW-1:0] bal;
    logic [AW-1:0] damt;
    logic [3:0]    tries;
    logic [4:0]    p;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  atm_state_e m_st;
  int         m_bal, m_damt, m_tries, m_quiet;
  logic [4:0] m_p;

  function automatic in_t mk_in(bit card, bit cxl, bit pv, bit pok, int bin,
                                bit ov, int os, bit av, int a);
    in_t r;
    r.card = card; r.cancel = cxl; r.pv = pv; r.pok = pok; r.bin = AW'(bin);
    r.ov = ov; r.os = 2'(os); r.av = av; r.a = AW'(a);
    return r;
  endfunction

  function automatic in_t in_card(bit card);  return mk_in(card, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic in_t in_pin(bit ok, int b); return mk_in(1, 0, 1, ok, b, 0, 0, 0, 0); endfunction
  function automatic in_t in_op(int os);       return mk_in(1, 0, 0, 0, 0, 1, os, 0, 0); endfunction
  function automatic in_t in_amt(int a);       return mk_in(1, 0, 0, 0, 0, 0, 0, 1, a); endfunction
  function automatic in_t in_cancel();         return mk_in(1, 1, 0, 0, 0, 0, 0, 0, 0); endfunction

  function automatic out_t mk_out(atm_state_e st, int bal, int damt, int tries, logic [4:0] p);
    out_t r;
    r.st = st; r.bal = AW'(bal); r.damt = AW'(damt); r.tries = 4'(tries); r.p = p;
    return r;
  endfunction

  function automatic out_t dut_out();
    return {state_o, bal_o, dispense_amt, tries_left, {bal_show, dispense, insuff, eject, capture}};
  endfunction

  task automatic add(input in_t i, input out_t o);
    vec_t v;
    v.i = i; v.o = o;
    vecs.push_back(v);
  endtask

  task automatic check_out(input string name, input out_t exp);
    out_t act;
    act = dut_out();
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got st=%0d bal=%0d damt=%0d tries=%0d pulses=%b ; expected st=%0d bal=%0d damt=%0d tries=%0d pulses=%b",
               name, act.st, act.bal, act.damt, act.tries, act.p,
               exp.st, exp.bal, exp.damt, exp.tries, exp.p);
    end
  endtask

  task automatic drive(input in_t x);
    card_in = x.card; cancel = x.cancel; pin_vld = x.pv; pin_ok = x.pok; bal_in = x.bin;
    op_vld = x.ov; op_sel = x.os; amt_vld = x.av; amt = x.a;
  endtask

  task automatic step(input in_t x);
    drive(x);
    @(posedge clk);
    #1;
  endtask

  task automatic model_go_idle();
    m_st = ST_IDLE; m_bal = 0; m_tries = MAX;
  endtask

  // Session rules applied to one cycle of inputs; predicts the outputs seen after the edge.
  task automatic model_step(input in_t x);
    atm_state_e prev;
    bit listening, strobe, expired;
    prev      = m_st;
    listening = (m_st == ST_PIN) || (m_st == ST_MENU) || (m_st == ST_AMOUNT);
    strobe    = x.cancel | x.pv | x.ov | x.av;
    expired   = 1'b0;
`ifdef ATM_TIMEOUT_EN
    expired = listening && (m_quiet == TO - 1);
`endif
    m_p = P_NONE;
    if (listening && !x.card) begin
      model_go_idle();
    end else if (listening && (x.cancel || expired)) begin
      m_st = ST_EJECT; m_p = P_EJ;
    end else begin
      case (m_st)
        ST_IDLE: if (x.card) m_st = ST_PIN;
        ST_PIN: if (x.pv) begin
          if (x.pok) begin
            m_st = ST_MENU; m_bal = int'(x.bin); m_tries = MAX;
          end else begin
            m_tries--;
            if (m_tries == 0) begin m_st = ST_CAPTURE; m_p = P_CAP; end
          end
        end
        ST_MENU: if (x.ov) begin
          if (x.os == 2'b00)      begin m_st = ST_SHOW; m_p = P_SHOW; end
          else if (x.os == 2'b01) m_st = ST_AMOUNT;
          else if (x.os == 2'b11) begin m_st = ST_EJECT; m_p = P_EJ; end
        end
        ST_AMOUNT: if (x.av) begin
          if (x.a == '0) m_st = ST_MENU;
          else if (int'(x.a) <= m_bal) begin
            m_bal -= int'(x.a); m_damt = int'(x.a); m_st = ST_DISPENSE; m_p = P_DISP;
          end else begin
            m_st = ST_MENU; m_p = P_INS;
          end
        end
        ST_SHOW, ST_DISPENSE: m_st = ST_MENU;
        default: if (!x.card) model_go_idle();
      endcase
    end
    m_quiet = (m_st != prev || strobe) ? 0 : m_quiet + 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_t x;

    // Withdrawal flow, insufficient funds, exact drain, dropped/ignored strobes.
    add(in_card(1),   mk_out(ST_PIN,      0,   0,  3, P_NONE));
    add(in_pin(1,100),mk_out(ST_MENU,     100, 0,  3, P_NONE));
    add(in_op(1),     mk_out(ST_AMOUNT,   100, 0,  3, P_NONE));
    add(in_amt(40),   mk_out(ST_DISPENSE, 60,  40, 3, P_DISP));
    add(in_card(1),   mk_out(ST_MENU,     60,  40, 3, P_NONE));
    add(in_op(1),     mk_out(ST_AMOUNT,   60,  40, 3, P_NONE));
    add(in_amt(61),   mk_out(ST_MENU,     60,  40, 3, P_INS));
    add(in_op(1),     mk_out(ST_AMOUNT,   60,  40, 3, P_NONE));
    add(in_amt(60),   mk_out(ST_DISPENSE, 0,   60, 3, P_DISP));
    add(in_card(1),   mk_out(ST_MENU,     0,   60, 3, P_NONE));
    add(in_op(0),     mk_out(ST_SHOW,     0,   60, 3, P_SHOW));
    add(in_card(1),   mk_out(ST_MENU,     0,   60, 3, P_NONE));
    add(in_op(2),     mk_out(ST_MENU,     0,   60, 3, P_NONE));
    add(in_op(1),     mk_out(ST_AMOUNT,   0,   60, 3, P_NONE));
    add(in_amt(0),    mk_out(ST_MENU,     0,   60, 3, P_NONE));
    add(in_op(1),     mk_out(ST_AMOUNT,   0,   60, 3, P_NONE));
    add(in_amt(1),    mk_out(ST_MENU,     0,   60, 3, P_INS));
    add(in_op(3),     mk_out(ST_EJECT,    0,   60, 3, P_EJ));
    add(in_card(1),   mk_out(ST_EJECT,    0,   60, 3, P_NONE));
    add(in_card(0),   mk_out(ST_IDLE,     0,   60, 3, P_NONE));
    // PIN lockout.
    add(in_card(1),   mk_out(ST_PIN,      0,   60, 3, P_NONE));
    add(in_pin(0,0),  mk_out(ST_PIN,      0,   60, 2, P_NONE));
    add(in_pin(0,0),  mk_out(ST_PIN,      0,   60, 1, P_NONE));
    add(in_pin(0,0),  mk_out(ST_CAPTURE,  0,   60, 0, P_CAP));
    add(in_card(1),   mk_out(ST_CAPTURE,  0,   60, 0, P_NONE));
    add(in_card(0),   mk_out(ST_IDLE,     0,   60, 3, P_NONE));
    // Strobes dropped in MENU, then card pulled mid-session.
    add(in_card(1),   mk_out(ST_PIN,      0,   60, 3, P_NONE));
    add(in_pin(1,500),mk_out(ST_MENU,     500, 60, 3, P_NONE));
    add(in_pin(1,9),  mk_out(ST_MENU,     500, 60, 3, P_NONE));
    add(in_amt(5),    mk_out(ST_MENU,     500, 60, 3, P_NONE));
    add(in_card(0),   mk_out(ST_IDLE,     0,   60, 3, P_NONE));
    // Good PIN restores tries; cancel from MENU.
    add(in_card(1),   mk_out(ST_PIN,      0,   60, 3, P_NONE));
    add(in_pin(0,0),  mk_out(ST_PIN,      0,   60, 2, P_NONE));
    add(in_pin(1,7),  mk_out(ST_MENU,     7,   60, 3, P_NONE));
    add(in_cancel(),  mk_out(ST_EJECT,    7,   60, 3, P_EJ));
    add(in_card(0),   mk_out(ST_IDLE,     0,   60, 3, P_NONE));

    drive(in_card(0));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", mk_out(ST_IDLE, 0, 0, 3, P_NONE));
    rst = 1'b0;

    foreach (vecs[k]) begin
      step(vecs[k].i);
      check_out($sformatf("vec%0d", k), vecs[k].o);
    end

    // Cancel beats a simultaneous bad PIN: no try consumed.
    step(in_card(1));
    check_out("t4_pin", mk_out(ST_PIN, 0, 60, 3, P_NONE));
    x = in_pin(0, 0);
    x.cancel = 1'b1;
    step(x);
    check_out("t4_cancel", mk_out(ST_EJECT, 0, 60, 3, P_EJ));
    step(in_card(0));
    check_out("t4_idle", mk_out(ST_IDLE, 0, 60, 3, P_NONE));

    // Idle in MENU for TO cycles.
    step(in_card(1));
    step(in_pin(1, 50));
    check_out("t5_menu", mk_out(ST_MENU, 50, 60, 3, P_NONE));
    repeat (TO - 1) step(in_card(1));
    check_out("t5_wait", mk_out(ST_MENU, 50, 60, 3, P_NONE));
    step(in_card(1));
`ifdef ATM_TIMEOUT_EN
    check_out("t5_timeout", mk_out(ST_EJECT, 50, 60, 3, P_EJ));
`else
    check_out("t5_no_timeout", mk_out(ST_MENU, 50, 60, 3, P_NONE));
`endif
    step(in_card(0));
    check_out("t5_idle", mk_out(ST_IDLE, 0, 60, 3, P_NONE));

    // Reset while in AMOUNT with a withdrawal strobe pending.
    step(in_card(1));
    step(in_pin(1, 100));
    step(in_op(1));
    check_out("t6_amount", mk_out(ST_AMOUNT, 100, 60, 3, P_NONE));
    drive(in_amt(10));
    rst = 1'b1;
    #1;
    check_out("t6_rst_async", mk_out(ST_IDLE, 0, 0, 3, P_NONE));
    @(posedge clk);
    #1;
    check_out("t6_rst_hold", mk_out(ST_IDLE, 0, 0, 3, P_NONE));
    rst = 1'b0;
    step(in_card(0));
    check_out("t6_after", mk_out(ST_IDLE, 0, 0, 3, P_NONE));

    // Randomized sessions against the model.
    m_st = ST_IDLE; m_bal = 0; m_damt = 0; m_tries = MAX; m_quiet = 0; m_p = P_NONE;
    for (int n = 0; n < 3000; n++) begin
      x        = '0;
      x.card   = ($urandom_range(0, 24) != 0);
      x.cancel = ($urandom_range(0, 19) == 0);
      x.pv     = ($urandom_range(0, 3) == 0);
      x.pok    = ($urandom_range(0, 3) != 0);
      x.bin    = AW'($urandom_range(0, 300));
      x.ov     = ($urandom_range(0, 2) == 0);
      x.os     = 2'($urandom_range(0, 3));
      x.av     = ($urandom_range(0, 2) == 0);
      x.a      = ($urandom_range(0, 7) == 0) ? AW'(m_bal) : AW'($urandom_range(0, 150));
      model_step(x);
      step(x);
      check_out($sformatf("rand%0d", n), mk_out(m_st, m_bal, m_damt, m_tries, m_p));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
